// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-ROM port arbiter.
package imem_port_arbiter_pkg;

    localparam int unsigned DefAddrW     = 30;
    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefStarveMax = 8;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCpu  = 2'd1,
        OwnDbg  = 2'd2
    } owner_e;

    function automatic int unsigned starve_w(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the arbiter (slave view) and its CPU/debug/ROM neighbours (master view).
interface imem_port_arbiter_if #(
    parameter int unsigned ADDR_W = imem_port_arbiter_pkg::DefAddrW,
    parameter int unsigned DATA_W = imem_port_arbiter_pkg::DefDataW
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_inst;

    modport slave (
        input  cpu_req, cpu_addr, dbg_req, dbg_addr, mem_inst,
        output cpu_stall, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, dbg_req, dbg_addr, mem_inst,
        input  cpu_stall, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr
    );

endinterface

// File: rtl/imem_starve_ctr.sv
// Saturating starvation counter: clear has priority, increments stop at MaxCount.
module imem_starve_ctr #(
    parameter int unsigned MaxCount = 8,
    parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic            at_max_o,
    output logic [CntW-1:0] cnt_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxCount);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CntMax);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction ROM between CPU fetch and debug reads.
// CPU has priority; a debug request is forced through after STARVE_MAX denials.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned STARVE_MAX = DefStarveMax
) (
    input logic                clk,
    input logic                rst,
    imem_port_arbiter_if.slave bus
);

    localparam int unsigned StarveW = starve_w(STARVE_MAX);

    owner_e              grant;
    owner_e              owner_d, owner_q;
    logic                dbg_force;
    logic                at_max;
    logic                starve_inc, starve_clr;
    logic [StarveW-1:0]  starve_q;
    logic                cpu_rvalid, dbg_rvalid;

    imem_starve_ctr #(
        .MaxCount (STARVE_MAX),
        .CntW     (StarveW)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .at_max_o (at_max),
        .cnt_o    (starve_q)
    );

    always_comb begin
        dbg_force = bus.dbg_req & at_max;
        grant     = OwnNone;
        if (!rst) begin
            if (dbg_force) begin
                grant = OwnDbg;
            end else if (bus.cpu_req) begin
                grant = OwnCpu;
            end else if (bus.dbg_req) begin
                grant = OwnDbg;
            end
        end
        owner_d = grant;
    end

    always_comb begin
        case (grant)
            OwnCpu:  bus.mem_addr = bus.cpu_addr;
            OwnDbg:  bus.mem_addr = bus.dbg_addr;
            default: bus.mem_addr = '0;
        endcase
    end

    assign starve_clr = rst | ~bus.dbg_req | (grant == OwnDbg);
    assign starve_inc = bus.dbg_req & (grant != OwnDbg);

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Gating with rst drops a read whose grant landed the cycle before reset.
    assign cpu_rvalid = (owner_q == OwnCpu) & ~rst;
    assign dbg_rvalid = (owner_q == OwnDbg) & ~rst;

    assign bus.cpu_stall  = bus.cpu_req & (grant != OwnCpu);
    assign bus.dbg_gnt    = (grant == OwnDbg);
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_inst : '0;
    assign bus.dbg_rdata  = dbg_rvalid ? bus.mem_inst : '0;

endmodule
